// File: rtl/rob_buffer.sv
// In-order reorder buffer: allocates at issue, takes out-of-order completions from
// the C_WB (fast) and SLREG (slow) ports, retires in program order. Option: ROB_COMMIT_BYPASS_EN.
module rob_buffer #(
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              alloc_valid,
    input  logic [DATA_W-1:0] alloc_pc,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_index,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_index,
    input  logic [4:0]        wb_rd,
    input  logic [DATA_W-1:0] wb_value,
    input  logic              wb_write,
    input  logic              sl_valid,
    input  logic [IDX_W-1:0]  sl_index,
    input  logic [4:0]        sl_rd,
    input  logic [DATA_W-1:0] sl_value,
    input  logic              sl_write,
    input  logic              commit_stall,
    output logic              commit_valid,
    output logic [IDX_W-1:0]  commit_index,
    output logic [DATA_W-1:0] commit_pc,
    output logic [4:0]        commit_rd,
    output logic [DATA_W-1:0] commit_value,
    output logic              commit_write,
    output logic [IDX_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic              collision_err
);
    logic [DEPTH-1:0]             ent_valid, ent_done, ent_write;
    logic [DEPTH-1:0][DATA_W-1:0] ent_pc, ent_value;
    logic [DEPTH-1:0][4:0]        ent_rd;
    logic [IDX_W-1:0]             head, tail;

    logic              collide, wb_hit, sl_hit, do_alloc, head_ready, do_retire;
    logic [4:0]        ret_rd;
    logic [DATA_W-1:0] ret_value;
    logic              ret_write;

    assign full        = (count == (IDX_W+1)'(DEPTH));
    assign empty       = (count == '0);
    assign alloc_ready = !full;
    assign alloc_index = tail;

    // Fast path wins a same-index collision; the slow write is dropped entirely.
    assign collide  = wb_valid && sl_valid && (wb_index == sl_index);
    assign wb_hit   = wb_valid && ent_valid[wb_index];
    assign sl_hit   = sl_valid && ent_valid[sl_index] && !collide;
    assign do_alloc = alloc_valid && !full;

`ifdef ROB_COMMIT_BYPASS_EN
    logic wb_head, sl_head;
    assign wb_head    = wb_hit && (wb_index == head);
    assign sl_head    = sl_hit && (sl_index == head);
    assign head_ready = ent_valid[head] && (ent_done[head] || wb_head || sl_head);

    always_comb begin
        ret_rd    = ent_rd[head];
        ret_value = ent_value[head];
        ret_write = ent_write[head];
        if (wb_head) begin
            ret_rd    = wb_rd;
            ret_value = wb_value;
            ret_write = wb_write;
        end else if (sl_head) begin
            ret_rd    = sl_rd;
            ret_value = sl_value;
            ret_write = sl_write;
        end
    end
`else
    assign head_ready = ent_valid[head] && ent_done[head];
    assign ret_rd     = ent_rd[head];
    assign ret_value  = ent_value[head];
    assign ret_write  = ent_write[head];
`endif

    assign do_retire = head_ready && !commit_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid     <= '0;
            ent_done      <= '0;
            ent_write     <= '0;
            ent_pc        <= '0;
            ent_value     <= '0;
            ent_rd        <= '0;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            commit_valid  <= 1'b0;
            commit_index  <= '0;
            commit_pc     <= '0;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_write  <= 1'b0;
            collision_err <= 1'b0;
        end else begin
            collision_err <= collide;
            if (flush) begin
                ent_valid    <= '0;
                ent_done     <= '0;
                head         <= '0;
                tail         <= '0;
                count        <= '0;
                commit_valid <= 1'b0;
            end else begin
                if (sl_hit) begin
                    ent_done[sl_index]  <= 1'b1;
                    ent_rd[sl_index]    <= sl_rd;
                    ent_value[sl_index] <= sl_value;
                    ent_write[sl_index] <= sl_write;
                end
                if (wb_hit) begin
                    ent_done[wb_index]  <= 1'b1;
                    ent_rd[wb_index]    <= wb_rd;
                    ent_value[wb_index] <= wb_value;
                    ent_write[wb_index] <= wb_write;
                end
                // Clearing the head after the completion writes lets a bypassed head
                // completion retire without leaving a stale done bit behind.
                commit_valid <= do_retire;
                if (do_retire) begin
                    commit_index    <= head;
                    commit_pc       <= ent_pc[head];
                    commit_rd       <= ret_rd;
                    commit_value    <= ret_value;
                    commit_write    <= ret_write;
                    ent_valid[head] <= 1'b0;
                    ent_done[head]  <= 1'b0;
                    head            <= head + IDX_W'(1);
                end
                if (do_alloc) begin
                    ent_valid[tail] <= 1'b1;
                    ent_done[tail]  <= 1'b0;
                    ent_pc[tail]    <= alloc_pc;
                    tail            <= tail + IDX_W'(1);
                end
                count <= count + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_retire);
            end
        end
    end
endmodule

// File: tb/tb_rob_buffer.sv
// Bench for rob_buffer: directed scenarios then random traffic, all checked against a
// queue-based program-order model.
module tb_rob_buffer;
    localparam int DEPTH = 8, IDX_W = 3, DATA_W = 32;
`ifdef ROB_COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, flush = 1'b0, alloc_valid = 1'b0, commit_stall = 1'b0;
    logic [DATA_W-1:0] alloc_pc = '0;
    logic wb_valid = 1'b0, wb_write = 1'b0, sl_valid = 1'b0, sl_write = 1'b0;
    logic [IDX_W-1:0] wb_index = '0, sl_index = '0;
    logic [4:0] wb_rd = '0, sl_rd = '0;
    logic [DATA_W-1:0] wb_value = '0, sl_value = '0;
    logic alloc_ready, commit_valid, commit_write, full, empty, collision_err;
    logic [IDX_W-1:0] alloc_index, commit_index;
    logic [DATA_W-1:0] commit_pc, commit_value;
    logic [4:0] commit_rd;
    logic [IDX_W:0] count;

    rob_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .alloc_index(alloc_index),
        .wb_valid(wb_valid), .wb_index(wb_index), .wb_rd(wb_rd), .wb_value(wb_value), .wb_write(wb_write),
        .sl_valid(sl_valid), .sl_index(sl_index), .sl_rd(sl_rd), .sl_value(sl_value), .sl_write(sl_write),
        .commit_stall(commit_stall), .commit_valid(commit_valid), .commit_index(commit_index),
        .commit_pc(commit_pc), .commit_rd(commit_rd), .commit_value(commit_value), .commit_write(commit_write),
        .count(count), .full(full), .empty(empty), .collision_err(collision_err)
    );

    // Model: in-flight instructions in program order; q[0] is the oldest and lives at m_head.
    typedef struct {
        logic [DATA_W-1:0] pc;
        bit                done;
        logic [4:0]        rd;
        logic [DATA_W-1:0] value;
        bit                write;
    } ent_t;
    ent_t q[$];
    int m_head = 0;
    bit e_cv = 0, e_cw = 0, e_coll = 0;
    int e_ci = 0;
    logic [DATA_W-1:0] e_cpc = '0, e_cval = '0;
    logic [4:0] e_crd = '0;

    int checks = 0, errors = 0;
    bit log_en = 0;
    logic [DATA_W-1:0] got_val[$], got_pc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pos(input logic [IDX_W-1:0] idx);
        return (int'(idx) - m_head + DEPTH) % DEPTH;
    endfunction

    task automatic model_update();
        int sz;
        bit wbh, slh, retire;
        ent_t h;
        if (reset) begin
            q.delete(); m_head = 0;
            e_cv = 0; e_ci = 0; e_cpc = '0; e_crd = '0; e_cval = '0; e_cw = 0; e_coll = 0;
            return;
        end
        e_coll = wb_valid && sl_valid && (wb_index == sl_index);
        if (flush) begin
            q.delete(); m_head = 0; e_cv = 0;
            return;
        end
        sz  = q.size();
        wbh = wb_valid && pos(wb_index) < sz;
        slh = sl_valid && pos(sl_index) < sz && !e_coll;
        h   = '{pc: '0, done: 0, rd: '0, value: '0, write: 0};
        if (sz > 0) h = q[0];
        if (BYP && wbh && pos(wb_index) == 0) begin
            h.done = 1; h.rd = wb_rd; h.value = wb_value; h.write = wb_write;
        end else if (BYP && slh && pos(sl_index) == 0) begin
            h.done = 1; h.rd = sl_rd; h.value = sl_value; h.write = sl_write;
        end
        retire = sz > 0 && h.done && !commit_stall;
        if (slh) q[pos(sl_index)] = '{pc: q[pos(sl_index)].pc, done: 1, rd: sl_rd, value: sl_value, write: sl_write};
        if (wbh) q[pos(wb_index)] = '{pc: q[pos(wb_index)].pc, done: 1, rd: wb_rd, value: wb_value, write: wb_write};
        e_cv = retire;
        if (retire) begin
            e_ci = m_head; e_cpc = h.pc; e_crd = h.rd; e_cval = h.value; e_cw = h.write;
            void'(q.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (alloc_valid && sz < DEPTH)
            q.push_back('{pc: alloc_pc, done: 0, rd: '0, value: '0, write: 0});
    endtask

    task automatic check_model();
        chk("alloc_ready", alloc_ready, q.size() < DEPTH);
        chk("alloc_index", alloc_index, (m_head + q.size()) % DEPTH);
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("commit_valid", commit_valid, e_cv);
        chk("commit_index", commit_index, e_ci);
        chk("commit_pc", commit_pc, e_cpc);
        chk("commit_rd", commit_rd, e_crd);
        chk("commit_value", commit_value, e_cval);
        chk("commit_write", commit_write, e_cw);
        chk("collision_err", collision_err, e_coll);
    endtask

    // One clock: model predicts the edge, DUT takes it, outputs checked 1 time unit later.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_model();
        if (log_en && commit_valid) begin
            got_val.push_back(commit_value);
            got_pc.push_back(commit_pc);
        end
    endtask

    task automatic idle();
        reset = 0; flush = 0; alloc_valid = 0; wb_valid = 0; sl_valid = 0; commit_stall = 0;
    endtask

    task automatic do_reset();
        idle(); reset = 1; step(); step(); reset = 0;
        got_val.delete(); got_pc.delete();
    endtask

    task automatic alloc(input logic [DATA_W-1:0] pc);
        idle(); alloc_valid = 1; alloc_pc = pc; step(); alloc_valid = 0;
    endtask

    task automatic set_wb(input int idx, input logic [4:0] rd, input logic [DATA_W-1:0] v);
        wb_valid = 1; wb_index = IDX_W'(idx); wb_rd = rd; wb_value = v; wb_write = 1;
    endtask

    task automatic set_sl(input int idx, input logic [4:0] rd, input logic [DATA_W-1:0] v);
        sl_valid = 1; sl_index = IDX_W'(idx); sl_rd = rd; sl_value = v; sl_write = 1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_empty", empty, 1); chk("rst_ready", alloc_ready, 1);

        // Allocation and in-order retire
        log_en = 1;
        chk("a0_idx", alloc_index, 0); alloc(32'h100);
        chk("a1_idx", alloc_index, 1); alloc(32'h104);
        chk("a2_idx", alloc_index, 2); alloc(32'h108);
        chk("a_count", count, 3);
        idle(); set_wb(2, 3, 32'hC); step();
        idle(); step(); chk("no_early_commit", commit_valid, 0);
        idle(); set_wb(0, 1, 32'hA); step();
        idle(); set_sl(1, 2, 32'hB); step();
        idle(); repeat (4) step();
        chk("order_n", got_val.size(), 3);
        if (got_val.size() == 3) begin
            chk("order_0", got_val[0], 32'hA); chk("order_1", got_val[1], 32'hB); chk("order_2", got_val[2], 32'hC);
        end
        chk("order_cnt", count, 0);

        // Full and wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(32'h300 + 4 * i);
        chk("full", full, 1); chk("full_ready", alloc_ready, 0);
        alloc(32'hDEAD); chk("ninth_ignored", count, DEPTH);
        idle(); set_wb(0, 4, 32'h50); step();
        idle(); step(); step();
        chk("wrap_idx", alloc_index, 0);
        alloc(32'h200);
        for (int i = 1; i <= DEPTH; i++) begin idle(); set_wb(i % DEPTH, 5, 32'h60 + i); step(); end
        idle(); repeat (3) step();
        chk("wrap_n", got_pc.size(), DEPTH + 1);
        if (got_pc.size() > 0) chk("wrap_pc", got_pc[got_pc.size()-1], 32'h200);

        // Port collision
        do_reset();
        alloc(32'h400); alloc(32'h404);
        idle(); set_wb(1, 6, 32'h11); set_sl(1, 7, 32'h22); step();
        chk("coll_pulse", collision_err, 1);
        idle(); set_wb(0, 6, 32'h10); step();
        chk("coll_once", collision_err, 0);
        idle(); repeat (3) step();
        if (got_val.size() == 2) chk("coll_val", got_val[1], 32'h11);
        else chk("coll_n", got_val.size(), 2);

        // Flush
        do_reset();
        for (int i = 0; i < 5; i++) alloc(32'h500 + 4 * i);
        idle(); commit_stall = 1; set_wb(0, 1, 32'h1); set_sl(1, 2, 32'h2); step();
        idle(); flush = 1; alloc_valid = 1; alloc_pc = 32'h600; step();
        chk("fl_cv", commit_valid, 0); chk("fl_cnt", count, 0); chk("fl_empty", empty, 1); chk("fl_idx", alloc_index, 0);
        idle(); set_wb(3, 3, 32'h3); step();
        chk("fl_late", count, 0);
        idle(); step(); chk("fl_late_cv", commit_valid, 0);

        // Stall
        do_reset();
        alloc(32'h700);
        idle(); commit_stall = 1; set_wb(0, 9, 32'h99); step();
        for (int i = 0; i < 3; i++) begin idle(); commit_stall = 1; step(); chk("stall_hold", commit_valid, 0); end
        idle(); step(); chk("stall_release", commit_valid, 1);

        // Bypass timing
        do_reset();
        alloc(32'h800);
        idle(); set_wb(0, 8, 32'h88); step();
        chk("byp_edge_n", commit_valid, BYP);
        idle(); step();
        chk("byp_edge_n1", commit_valid, !BYP);

        // Random traffic
        log_en = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            reset        = ($urandom_range(0, 199) == 0);
            flush        = ($urandom_range(0, 49) == 0);
            commit_stall = ($urandom_range(0, 99) < 20);
            alloc_valid  = ($urandom_range(0, 99) < 55);
            alloc_pc     = $urandom;
            wb_valid = ($urandom_range(0, 99) < 45); wb_index = IDX_W'($urandom_range(0, DEPTH-1));
            wb_rd = 5'($urandom); wb_value = $urandom; wb_write = 1'($urandom);
            sl_valid = ($urandom_range(0, 99) < 45); sl_index = IDX_W'($urandom_range(0, DEPTH-1));
            sl_rd = 5'($urandom); sl_value = $urandom; sl_write = 1'($urandom);
            if ($urandom_range(0, 9) == 0) sl_index = wb_index;
            step();
        end
        idle(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_buffer.md
Name: rob_buffer

Overview:
- In-order reorder buffer for the PA-MIPS pipeline.
- Allocates an entry per instruction at issue and hands its index downstream as rob_index.
- Accepts out-of-order completions from two sources:
  - fast path: the C_WB register outputs;
  - slow path: the SLREG outputs.
- Retires entries strictly in program order to the register-file write port.

Parameters:
- DEPTH, 8, number of entries; must be a power of two.
- IDX_W, 3, index width; log2(DEPTH); matches the pipeline rob_index width.
- DATA_W, 32, width of the result value and the PC.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all entries, e.g. on branch mispredict or exception.
- alloc_valid  in  1  request to allocate one entry this cycle.
- alloc_pc  in  DATA_W  PC of the allocating instruction.
- alloc_ready  out  1  entry available; combinational, equal to !full.
- alloc_index  out  IDX_W  index granted on a handshake; equal to the tail pointer.
- wb_valid, wb_index[IDX_W], wb_rd[5], wb_value[DATA_W], wb_write[1]  in  fast-path completion.
- sl_valid, sl_index[IDX_W], sl_rd[5], sl_value[DATA_W], sl_write[1]  in  slow-path completion.
- commit_stall  in  1  hold retirement this cycle.
- commit_valid  out  1  registered one-cycle retirement pulse.
- commit_index  out  IDX_W  index of the retired entry.
- commit_pc  out  DATA_W  PC of the retired entry.
- commit_rd  out  5  destination register of the retired entry.
- commit_value  out  DATA_W  result value of the retired entry.
- commit_write  out  1  register-file write enable; only meaningful when commit_valid=1.
- count  out  IDX_W+1  occupied entries, range 0..DEPTH.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- collision_err  out  1  registered one-cycle pulse when both completion ports target the same index.

Behaviour:
- Per-entry state: valid, done, pc, rd, value, write. Pointers head and tail are IDX_W bits and wrap naturally from DEPTH-1 to 0.
- Reset:
  - All entries are cleared; head=tail=0; count=0.
  - commit_* outputs and collision_err are 0.
  - Consequently empty=1, full=0, alloc_ready=1, alloc_index=0.
- Allocate (alloc_valid && alloc_ready):
  - entry[tail] gets valid=1, done=0, pc=alloc_pc; tail increments.
  - alloc_valid while full is ignored; no state change.
- Completion port, when its valid is asserted and entry[idx].valid=1:
  - entry sets done=1 and latches rd, value, write.
  - Completion to an invalid entry is silently dropped.
  - Completion to an already-done entry overwrites it.
- Both ports valid with the same index: fast path (wb_*) wins, slow port is dropped, collision_err pulses the next cycle. Different indices both update.
- Retirement condition: entry[head].valid && entry[head].done && !commit_stall, evaluated at the edge.
- On retirement:
  - On that edge commit_valid<=1, and commit_index/pc/rd/value/write take entry[head].
  - entry[head] is cleared; head increments.
  - Otherwise commit_valid<=0; the other commit_* outputs hold their last values.
- Retirement rate: at most one entry per cycle.
- Latency: completion at edge N, retirement at edge N+1, commit_valid high during cycle N+1..N+2 (base build).
- count updates: alloc and retire on the same edge leave count unchanged.
- Full state: a same-cycle retirement does not credit alloc_ready; alloc_ready stays 0 that cycle.
- flush:
  - Clears all valid/done; head=tail=0; count=0; commit_valid<=0.
  - Has priority over alloc, completion and retirement on the same edge.
  - A completion arriving after flush targets an invalid entry and is dropped.
- Reset has priority over flush. Reset mid-operation discards all in-flight entries with no commit pulse.

Optional Feature:
- Macro: ROB_COMMIT_BYPASS_EN.
- Defined:
  - A completion for the current head index, on either port, is retirement-eligible on the same edge. Data is taken directly from the completion port, with the fast port winning on collision.
  - commit_valid rises one cycle earlier than in the base build.
  - commit_stall, flush and reset rules are unchanged.
- Undefined: a completion writes the entry first; retirement is evaluated on the stored done bit only.

Test Plan:
- Allocation and in-order retire:
  - Stimulus: reset, allocate pc 0x100/0x104/0x108 -> alloc_index 0,1,2; count=3.
  - Stimulus: complete idx2 (rd 3, 0xC), then idx0 (rd 1, 0xA), then idx1 (rd 2, 0xB).
  - Required: commits in order idx0/0xA, idx1/0xB, idx2/0xC; no commit before idx0 completes; count returns to 0.
- Full and wrap:
  - Stimulus: allocate 8 entries.
  - Required: full=1, alloc_ready=0, a 9th alloc_valid is ignored.
  - Stimulus: complete and retire idx0, then allocate pc 0x200.
  - Required: alloc_index=0; commit_pc later reads 0x200 after idx7 retires.
- Port collision: wb and sl both target idx1, values 0x11 and 0x22 -> entry holds 0x11; collision_err=1 for exactly one cycle; retires 0x11.
- Flush:
  - Stimulus: 5 entries, idx0 and idx1 done, flush asserted together with alloc_valid.
  - Required: no commit_valid; count=0; empty=1; next alloc_index=0; late completion to idx3 is dropped.
- Stall: head done, commit_stall high 3 cycles -> commit_valid stays 0; retires on the first cycle after the stall drops.
- Bypass timing:
  - Stimulus: head completion at edge N.
  - Required: commit_valid sampled high after edge N with ROB_COMMIT_BYPASS_EN defined; after edge N+1 without it.
